chacha20_xor_stream: RTL and testbench

Downstream consumer of chacha20_top. It drives chacha20_top's start and counter inputs, captures each 512-bit keystream block, and XORs it word-by-word into a 32-bit plaintext/ciphertext stream with valid/ready handshakes.
- Block counter advances once per consumed 64-byte block.
- Key and nonce are wired straight from the integrator to chacha20_top; this block does not touch them.

---
 rtl/chacha20_pkg.sv | 18 +
 rtl/chacha20_ks_buffer.sv | 46 ++++
 rtl/chacha20_xor_stream.sv | 164 ++++++++++++++++
 tb/tb_chacha20_xor_stream.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
// Shared types and constants for the ChaCha20 keystream consumer.
// Latency: n/a; backpressure: n/a.
package chacha20_pkg;

    localparam int CHACHA_BLOCK_WORDS = 16;
    localparam int CHACHA_WORD_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_HALT
    } xs_state_e;

    // Element i occupies bits [i*32 +: 32], matching chacha20_top's keystream bus.
    typedef logic [CHACHA_BLOCK_WORDS-1:0][CHACHA_WORD_W-1:0] ks_block_t;

endpackage

// File: rtl/chacha20_ks_buffer.sv
// Holds one 512-bit keystream block and walks its 32-bit words in order.
// Latency: current word is combinational from the index; backpressure: advance only on accepted words.
module chacha20_ks_buffer
    import chacha20_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  ks_block_t                blk_i,
    input  logic                     advance_i,
    output logic [CHACHA_WORD_W-1:0] word_o,
    output logic                     last_o
);

    ks_block_t  blk_q;
    logic [3:0] idx_q;
    logic [3:0] idx_d;

    // Block contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load_i) begin
            blk_q <= blk_i;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = '0;
        end else if (advance_i) begin
            idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign word_o = blk_q[idx_q];
    assign last_o = (idx_q == 4'(CHACHA_BLOCK_WORDS - 1));

endmodule

// File: rtl/chacha20_xor_stream.sv
// Requests ChaCha20 keystream blocks and XORs them word-by-word into a 32-bit stream.
// Latency: 1 cycle accept-to-out_valid; backpressure: in_ready = !out_valid || out_ready while streaming.
module chacha20_xor_stream
    import chacha20_pkg::*;
#(
    parameter int BLOCK_WORDS    = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_init,
    input  logic [31:0]  init_counter,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         ks_start,
    output logic [31:0]  ks_counter,
    input  logic [511:0] ks_keystream,
    input  logic         ks_done,
    output logic         busy,
    output logic         ctr_err,
    output logic         ks_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    if (BLOCK_WORDS != CHACHA_BLOCK_WORDS) begin : g_bad_block_words
        $error("chacha20_xor_stream: only 16-word blocks are supported");
    end

    xs_state_e    state_q, state_d;
    logic [31:0]  ctr_q, ctr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic         ks_start_q, ks_start_d;
    logic         ctr_err_q, ctr_err_d;
    logic         ks_timeout_q, ks_timeout_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_data_q, out_data_d;
    logic         out_last_q, out_last_d;

    logic         accept;
    logic         buf_load;
    logic [31:0]  buf_word;
    logic         buf_last;

    assign in_ready = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign buf_load = (state_q == ST_FETCH) && ks_done;

    chacha20_ks_buffer u_ks_buffer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (buf_load),
        .blk_i     (ks_keystream),
        .advance_i (accept),
        .word_o    (buf_word),
        .last_o    (buf_last)
    );

    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        tmo_d        = tmo_q;
        ks_start_d   = ks_start_q;
        ctr_err_d    = ctr_err_q;
        ks_timeout_d = ks_timeout_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;

        case (state_q)
            // Errors are only ever set on the way into HALT, so clearing them here is safe in IDLE too.
            ST_IDLE, ST_HALT: begin
                if (msg_init) begin
                    ctr_d        = init_counter;
                    tmo_d        = '0;
                    ks_start_d   = 1'b1;
                    ctr_err_d    = 1'b0;
                    ks_timeout_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (ks_done) begin
                    ks_start_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = ST_STREAM;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    ks_timeout_d = 1'b1;
                    ks_start_d   = 1'b0;
                    tmo_d        = '0;
                    state_d      = ST_HALT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = ST_IDLE;
                    end else if (buf_last) begin
                        if (ctr_q == 32'hFFFF_FFFF) begin
                            ctr_err_d = 1'b1;
                            state_d   = ST_HALT;
                        end else begin
                            ctr_d      = ctr_q + 32'd1;
                            ks_start_d = 1'b1;
                            state_d    = ST_FETCH;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The output register drains in every state, independent of the FSM.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ buf_word;
            out_last_d  = in_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ctr_q        <= '0;
            tmo_q        <= '0;
            ks_start_q   <= 1'b0;
            ctr_err_q    <= 1'b0;
            ks_timeout_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            tmo_q        <= tmo_d;
            ks_start_q   <= ks_start_d;
            ctr_err_q    <= ctr_err_d;
            ks_timeout_q <= ks_timeout_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign ks_start   = ks_start_q;
    assign ks_counter = ctr_q;
    assign ctr_err    = ctr_err_q;
    assign ks_timeout = ks_timeout_q;
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_STREAM);

endmodule

// File: tb/tb_chacha20_xor_stream.sv
// Directed bench for chacha20_xor_stream with a behavioural keystream-source stub.
// Latency: n/a; backpressure: out_ready optionally toggled every cycle.
module tb_chacha20_xor_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic         msg_init;
    logic [31:0]  init_counter;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         ks_start;
    logic [31:0]  ks_counter;
    logic [511:0] ks_keystream;
    logic         ks_done;
    logic         busy;
    logic         ctr_err;
    logic         ks_timeout;

    chacha20_xor_stream dut (
        .clk          (clk),
        .reset        (reset),
        .msg_init     (msg_init),
        .init_counter (init_counter),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .ks_start     (ks_start),
        .ks_counter   (ks_counter),
        .ks_keystream (ks_keystream),
        .ks_done      (ks_done),
        .busy         (busy),
        .ctr_err      (ctr_err),
        .ks_timeout   (ks_timeout)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_starts = 0;
    int          bp_viol  = 0;
    bit          stub_en  = 1'b1;
    bit          bp_toggle = 1'b0;
    logic [32:0] outq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word 0 of the counter=1 block is the RFC 8439 keystream word (bytes 22 4f 51 f3).
    function automatic logic [31:0] ks_word(input logic [31:0] c, input int i);
        if (c == 32'd1 && i == 0) return 32'hf3514f22;
        return {c[15:0], 8'hA0 + 8'(i), c[31:24] ^ 8'h5C};
    endfunction

    function automatic logic [511:0] ks_block(input logic [31:0] c);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = ks_word(c, i);
        return b;
    endfunction

    // Keystream source: one-cycle done pulse 3 cycles after start rises.
    initial begin : stub
        bit st_busy;
        int st_cnt;
        st_busy = 1'b0;
        st_cnt  = 0;
        ks_done = 1'b0;
        ks_keystream = '0;
        forever begin
            @(negedge clk);
            ks_done = 1'b0;
            if (reset || !ks_start) begin
                st_busy = 1'b0;
                st_cnt  = 0;
            end else if (!st_busy && stub_en) begin
                st_cnt++;
                if (st_cnt == 3) begin
                    ks_keystream = ks_block(ks_counter);
                    ks_done = 1'b1;
                    st_busy = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        logic start_prev;
        start_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid && out_ready) outq.push_back({out_last, out_data});
                if (out_valid && !out_ready && in_ready) bp_viol++;
                if (ks_start && !start_prev) n_starts++;
            end
            start_prev = ks_start;
        end
    end

    initial begin : sink
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_toggle ? ~out_ready : 1'b1;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [31:0] d, input logic l, input int lim, output bit ok);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok = 1'b0;
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_msg(input logic [31:0] c);
        init_counter = c;
        msg_init = 1'b1;
        @(posedge clk);
        #1;
        msg_init = 1'b0;
    endtask

    task automatic wait_outs(input string tag, input int n);
        int k;
        k = 0;
        while (outq.size() < n && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(outq.size()), 64'(n));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"},  64'(out_valid),  64'd0);
        check({tag, "_out_data"},   64'(out_data),   64'd0);
        check({tag, "_out_last"},   64'(out_last),   64'd0);
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_ks_start"},   64'(ks_start),   64'd0);
        check({tag, "_ks_counter"}, 64'(ks_counter), 64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_ctr_err"},    64'(ctr_err),    64'd0);
        check({tag, "_ks_timeout"}, 64'(ks_timeout), 64'd0);
    endtask

    // Checks queue entry i against data ^ keystream of counter c, word w.
    task automatic check_word(input string tag, input int i, input logic [31:0] d,
                              input logic [31:0] c, input int w, input logic l);
        logic [32:0] got;
        got = (i < outq.size()) ? outq[i] : 33'h1_DEAD_BEEF;
        check($sformatf("%s_w%0d", tag, i), 64'(got), 64'({l, d ^ ks_word(c, w)}));
    endtask

    logic [31:0] words[32];
    bit          ok;
    int          acc_fail;
    int          n;

    initial begin
        reset = 1'b1;
        msg_init = 1'b0;
        init_counter = '0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        for (int i = 0; i < 32; i++) words[i] = (32'(i) * 32'h0102_0304) ^ 32'hCAFE_F00D;
        words[0] = 32'h6964614c;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // RFC vector plus two-block message: 29 words, counters 1 then 2.
        n_starts = 0;
        outq.delete();
        start_msg(32'd1);
        check("t1_ks_start", 64'(ks_start), 64'd1);
        check("t1_ks_counter", 64'(ks_counter), 64'd1);
        acc_fail = 0;
        for (int i = 0; i < 29; i++) begin
            send(words[i], i == 28, 200, ok);
            if (!ok) acc_fail++;
        end
        check("t1_accepts", 64'(acc_fail), 64'd0);
        wait_outs("t1", 29);
        check("t1_rfc_ladi", 64'(outq.size() > 0 ? outq[0][31:0] : 32'h0), 64'h9a352e6e);
        for (int i = 0; i < 29; i++)
            check_word("t1", i, words[i], (i < 16) ? 32'd1 : 32'd2, i % 16, i == 28);
        check("t1_busy_idle", 64'(busy), 64'd0);
        check("t1_starts", 64'(n_starts), 64'd2);

        // Backpressure: out_ready toggling every cycle.
        bp_toggle = 1'b1;
        outq.delete();
        start_msg(32'd7);
        acc_fail = 0;
        for (int i = 0; i < 20; i++) begin
            send(words[i + 5], i == 19, 200, ok);
            if (!ok) acc_fail++;
        end
        check("t2_accepts", 64'(acc_fail), 64'd0);
        wait_outs("t2", 20);
        bp_toggle = 1'b0;
        for (int i = 0; i < 20; i++)
            check_word("t2", i, words[i + 5], (i < 16) ? 32'd7 : 32'd8, i % 16, i == 19);

        // Counter wrap: block at 0xFFFFFFFF is the last one allowed.
        outq.delete();
        start_msg(32'hFFFF_FFFF);
        acc_fail = 0;
        for (int i = 0; i < 16; i++) begin
            send(words[i], 1'b0, 200, ok);
            if (!ok) acc_fail++;
        end
        check("t3_accepts", 64'(acc_fail), 64'd0);
        send(words[16], 1'b0, 20, ok);
        check("t3_17th_rejected", 64'(ok), 64'd0);
        wait_outs("t3", 16);
        for (int i = 0; i < 16; i++)
            check_word("t3", i, words[i], 32'hFFFF_FFFF, i, 1'b0);
        check("t3_ctr_err", 64'(ctr_err), 64'd1);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_ctr_kept", 64'(ks_counter), 64'hFFFF_FFFF);
        outq.delete();
        start_msg(32'd0);
        check("t3_err_cleared", 64'(ctr_err), 64'd0);
        check("t3_restart_start", 64'(ks_start), 64'd1);
        check("t3_restart_ctr", 64'(ks_counter), 64'd0);
        send(words[3], 1'b1, 200, ok);
        wait_outs("t3b", 1);
        check_word("t3b", 0, words[3], 32'd0, 0, 1'b1);

        // Timeout: source never answers.
        stub_en = 1'b0;
        start_msg(32'd3);
        n = 0;
        while (!ks_timeout && n < 1100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_timeout_cycles", 64'(n), 64'd1023);
        check("t4_ks_timeout", 64'(ks_timeout), 64'd1);
        check("t4_ks_start", 64'(ks_start), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_in_ready", 64'(in_ready), 64'd0);
        stub_en = 1'b1;
        outq.delete();
        start_msg(32'd4);
        check("t4_timeout_cleared", 64'(ks_timeout), 64'd0);
        send(words[9], 1'b1, 200, ok);
        wait_outs("t4b", 1);
        check_word("t4b", 0, words[9], 32'd4, 0, 1'b1);

        // Reset mid-STREAM at word index 7.
        start_msg(32'd9);
        for (int i = 0; i < 7; i++) send(words[i], 1'b0, 200, ok);
        check("t5_busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("t5_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        outq.delete();
        start_msg(32'd5);
        check("t5_ks_start", 64'(ks_start), 64'd1);
        check("t5_ks_counter", 64'(ks_counter), 64'd5);
        send(words[20], 1'b0, 200, ok);
        send(words[21], 1'b1, 200, ok);
        wait_outs("t5", 2);
        check_word("t5", 0, words[20], 32'd5, 0, 1'b0);
        check_word("t5", 1, words[21], 32'd5, 1, 1'b1);

        check("bp_in_ready_held", 64'(bp_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
